// File: rtl/data_memory_line.sv
// Line-granular backing store answering the dcache line interface.
// Each request is latched, held for a fixed latency, then acknowledged with a one-cycle ack pulse.
module data_memory_line #(
  parameter int DEPTH   = 512,
  parameter int LATENCY = 10
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [31:0]  addr_i,
  input  logic [255:0] data_i,
  input  logic         enable_i,
  input  logic         write_i,
  output logic         ack_o,
  output logic [255:0] data_o,
  output logic         busy_o
);
  localparam int IW = $clog2(DEPTH);
  localparam int CW = $clog2(LATENCY + 1);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_ACK} state_e;

  state_e         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [IW-1:0]  idx_q;
  logic           wr_q;
  logic [255:0]   wdata_q;
  logic [255:0]   data_q;
  logic [255:0]   mem_q [DEPTH];
  logic           accept;
  logic           commit;

  // Offset and aliased upper address bits are intentionally dropped.
  logic unused_addr;
  assign unused_addr = ^{addr_i[31:5+IW], addr_i[4:0]};

  assign accept = (state_q == S_IDLE) && enable_i;
  assign commit = (state_q == S_BUSY) && (cnt_q == CW'(LATENCY));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: if (enable_i) begin
        state_d = S_BUSY;
        cnt_d   = CW'(1);
      end
      S_BUSY: begin
        if (commit) state_d = S_ACK;
        else        cnt_d   = cnt_q + CW'(1);
      end
      S_ACK: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      wr_q    <= 1'b0;
      wdata_q <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        idx_q   <= addr_i[5 +: IW];
        wr_q    <= write_i;
        wdata_q <= data_i;
      end
      if (commit && !wr_q) data_q <= mem_q[idx_q];
    end
  end

  // Array is never cleared; a write lands only on the edge entering ACK.
  always_ff @(posedge clk_i) begin
    if (commit && wr_q && !rst_i) mem_q[idx_q] <= wdata_q;
  end

  assign ack_o  = (state_q == S_ACK);
  assign busy_o = (state_q != S_IDLE);
  assign data_o = data_q;
endmodule
